// File: rtl/ram_loader.sv
// Loads a byte stream into consecutive RAM words from address 0, then optionally
// reads every word back and compares the additive checksum of what was written.
module ram_loader #(
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16,
    parameter int VERIFY_EN = 1,
    parameter int RD_WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data_in,
    input  logic [7:0]        ram_data_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        rsum_q, rsum_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        rsum_next;

    function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            csum_q  <= '0;
            rsum_q  <= '0;
            wait_q  <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            csum_q  <= csum_d;
            rsum_q  <= rsum_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; abort beats any transfer or read step in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (abort)           state_d = S_IDLE;
                else if (byte_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort)                  state_d = S_IDLE;
                else if (addr_q != LAST_ADDR) state_d = S_LOAD_WAIT;
                else if (VERIFY_EN != 0)    state_d = S_READ;
                else                        state_d = S_DONE;
            end
            S_READ: begin
                if (abort) state_d = S_IDLE;
                else if (wait_q == LAST_WAIT && addr_q == LAST_ADDR) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rsum_next = add_mod256(rsum_q, ram_data_out);

    // Output and datapath next values, derived from the state being entered
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        csum_d  = csum_q;
        rsum_d  = rsum_q;
        wait_d  = wait_q;
        err_d   = err_q;
        we_d    = (state_d == S_WRITE);
        oe_d    = (state_d == S_READ);
        busy_d  = (state_d == S_LOAD_WAIT) || (state_d == S_WRITE) || (state_d == S_READ);
        done_d  = (state_d == S_DONE);
        if (abort && state_q != S_IDLE) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d = '0;
                        csum_d = '0;
                        rsum_d = '0;
                        wait_d = '0;
                        err_d  = 1'b0;
                    end
                end
                S_LOAD_WAIT: begin
                    if (byte_valid) begin
                        wdata_d = byte_data;
                        csum_d  = add_mod256(csum_q, byte_data);
                    end
                end
                S_WRITE: begin
                    if (addr_q != LAST_ADDR) begin
                        addr_d = addr_q + 1'b1;
                    end else if (VERIFY_EN != 0) begin
                        addr_d = '0;
                        wait_d = '0;
                    end
                end
                S_READ: begin
                    if (wait_q == LAST_WAIT) begin
                        wait_d = '0;
                        rsum_d = rsum_next;
                        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
                        else                     err_d  = err_q | (rsum_next != csum_q);
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready  = (state_q == S_LOAD_WAIT);
    assign ram_we      = we_q;
    assign ram_oe      = oe_q;
    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign checksum    = csum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: default instance with a RAM model, plus a
// 4-word no-verify instance.
module tb_ram_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start, abort, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, ram_we, ram_oe, busy, done, error;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in, ram_data_out, checksum;

    logic       start6, abort6, byte_valid6;
    logic [7:0] byte_data6;
    logic       byte_ready6, ram_we6, ram_oe6, busy6, done6, error6;
    logic [3:0] ram_address6;
    logic [7:0] ram_data_in6, checksum6;
    logic [7:0] ram_data_out6 = 8'h00;

    ram_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    ram_loader #(.ADDR_W(4), .NUM_WORDS(4), .VERIFY_EN(0), .RD_WAIT(2)) dut6 (
        .clk(clk), .reset_n(reset_n), .start(start6), .abort(abort6),
        .byte_valid(byte_valid6), .byte_data(byte_data6), .byte_ready(byte_ready6),
        .ram_we(ram_we6), .ram_oe(ram_oe6), .ram_address(ram_address6),
        .ram_data_in(ram_data_in6), .ram_data_out(ram_data_out6),
        .busy(busy6), .done(done6), .error(error6), .checksum(checksum6)
    );

    // RAM model with an optional read fault at address 0xA
    logic [7:0] mem [16];
    logic       corrupt = 1'b0;
    always @(posedge clk) if (ram_we) mem[ram_address] <= ram_data_in;
    always_comb begin
        ram_data_out = 8'h00;
        if (ram_oe) ram_data_out = (corrupt && ram_address == 4'hA) ? 8'h00 : mem[ram_address];
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0, oe_cycles = 0, we_count = 0;
    int last_we6_cyc = -1, done6_cyc = -1;
    logic oe6_seen = 1'b0;
    logic [11:0] exp_wr[$];
    logic [8:0]  exp_done[$];
    logic [11:0] exp_wr6[$];
    int wr_addr = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitors: pop expected writes / done events whenever the DUTs present them
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (ram_we) begin
                we_count++;
                if (exp_wr.size() == 0) fail_now("write_unexpected", $sformatf("addr 0x%0h data 0x%0h", ram_address, ram_data_in));
                else chk("write_addr_data", 32'({ram_address, ram_data_in}), 32'(exp_wr.pop_front()));
                chk("we_oe_exclusive", 32'(ram_oe), 32'h0);
            end
            if (ram_oe) oe_cycles++;
            if (done) begin
                if (exp_done.size() == 0) fail_now("done_unexpected", $sformatf("error %0b checksum 0x%0h", error, checksum));
                else chk("done_error_checksum", 32'({error, checksum}), 32'(exp_done.pop_front()));
            end
            if (ram_we6) begin
                last_we6_cyc = cyc;
                if (exp_wr6.size() == 0) fail_now("write6_unexpected", $sformatf("addr 0x%0h", ram_address6));
                else chk("write6_addr_data", 32'({ram_address6, ram_data_in6}), 32'(exp_wr6.pop_front()));
            end
            if (ram_oe6) oe6_seen = 1'b1;
            if (done6) done6_cyc = cyc;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_addr = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tmo;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        exp_wr.push_back({wr_addr[3:0], b});
        wr_addr++;
        tmo = 0;
        while (!byte_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        if (!byte_ready) fail_now("byte_ready_timeout", "loader never became ready");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(done), 32'h1);
        @(negedge clk);
    endtask

    logic [7:0] stream2 [16] = '{8'h10, 8'h20, 8'h30, 8'hAB, 8'h40, 8'h50, 8'h60, 8'h70,
                                 8'h80, 8'h90, 8'hCD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        int base;
        int t;
        reset_n = 1'b0;
        start = 0; abort = 0; byte_valid = 0; byte_data = 0;
        start6 = 0; abort6 = 0; byte_valid6 = 0; byte_data6 = 0;
        #12;
        chk("reset_outputs", 32'({byte_ready, ram_we, ram_oe, ram_address, ram_data_in,
                                  busy, done, error, checksum}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: back-to-back stream 0x00..0x0F, verify pass
        base = oe_cycles;
        do_start();
        chk("t1_busy_after_start", 32'(busy), 32'h1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        byte_valid = 1'b0;
        exp_done.push_back({1'b0, 8'h78});
        wait_done("t1_done_seen");
        chk("t1_oe_cycles", 32'(oe_cycles - base), 32'd32);
        chk("t1_mem5", 32'(mem[5]), 32'h05);
        chk("t1_busy_after_done", 32'(busy), 32'h0);

        // 2: gapped stream
        base = we_count;
        do_start();
        for (int i = 0; i < 16; i++) send_byte(stream2[i], i % 3);
        byte_valid = 1'b0;
        exp_done.push_back({1'b0, 8'h47});
        wait_done("t2_done_seen");
        chk("t2_we_count", 32'(we_count - base), 32'd16);
        chk("t2_mem3", 32'(mem[3]), 32'hAB);
        chk("t2_memA", 32'(mem[10]), 32'hCD);

        // 3: read-back fault at 0xA
        corrupt = 1'b1;
        do_start();
        for (int i = 0; i < 16; i++) send_byte(stream2[i], 0);
        byte_valid = 1'b0;
        exp_done.push_back({1'b1, 8'h47});
        wait_done("t3_done_seen");
        repeat (2) @(negedge clk);
        chk("t3_error_sticky", 32'(error), 32'h1);
        chk("t3_checksum_held", 32'(checksum), 32'h47);
        corrupt = 1'b0;

        // 4: abort after 5 bytes
        base = we_count;
        do_start();
        chk("t4_error_cleared_by_start", 32'(error), 32'h0);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 0);
        byte_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t4_after_abort_we_oe_busy_err_done", 32'({ram_we, ram_oe, busy, error, done}), 32'b00010);
        repeat (4) @(negedge clk);
        chk("t4_we_count", 32'(we_count - base), 32'd5);
        chk("t4_mem4", 32'(mem[4]), 32'hA4);
        chk("t4_byte_ready_idle", 32'(byte_ready), 32'h0);

        // 5: start while busy ignored; async reset mid-READ
        do_start();
        chk("t5_error_cleared_by_start", 32'(error), 32'h0);
        for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i), 0);
        byte_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int i = 8; i < 16; i++) send_byte(8'h50 + 8'(i), 0);
        byte_valid = 1'b0;
        t = 0;
        while (!ram_oe && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t5_reached_read", 32'(ram_oe), 32'h1);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_reset_outputs", 32'({byte_ready, ram_we, ram_oe, ram_address, ram_data_in,
                                          busy, done, error, checksum}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 6: NUM_WORDS=4, no verify pass
        @(negedge clk);
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_valid6 = 1'b1;
            byte_data6  = 8'h31 + 8'(i);
            exp_wr6.push_back({4'(i), 8'h31 + 8'(i)});
            t = 0;
            while (!byte_ready6 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!byte_ready6) fail_now("t6_ready_timeout", "loader never became ready");
            @(posedge clk);
            #1;
        end
        byte_valid6 = 1'b0;
        t = 0;
        while (!done6 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t6_done_seen", 32'(done6), 32'h1);
        chk("t6_done_error", 32'(error6), 32'h0);
        chk("t6_checksum", 32'(checksum6), 32'hCA);
        @(negedge clk);
        chk("t6_done_latency", 32'(done6_cyc - last_we6_cyc), 32'd1);
        chk("t6_oe_never", 32'(oe6_seen), 32'h0);
        chk("t6_writes_consumed", 32'(exp_wr6.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
